cbus_line_master: RTL and testbench



---
 rtl/cbus_line_master_pkg.sv | 36 +++
 rtl/cbus_line_master_buf.sv | 39 +++
 rtl/cbus_line_master.sv | 123 ++++++++++++
 tb/tb_cbus_line_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_line_master_pkg.sv
// Shared CBus types and constants plus the line-transfer additions (line size, line type, FSM states).
package cbus_line_master_pkg;

    localparam int unsigned CBUS_ADDR_W     = 64;
    localparam int unsigned CBUS_DATA_W     = 64;
    localparam int unsigned CBUS_LINE_WORDS = 8;

    localparam logic [2:0] MSIZE8         = 3'd3;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef logic [CBUS_LINE_WORDS*CBUS_DATA_W-1:0] cbus_line_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [CBUS_ADDR_W-1:0] addr;
        logic [1:0]             burst;
        logic [2:0]             size;
        logic [7:0]             len;
        logic [CBUS_DATA_W-1:0] data;
        logic [7:0]             strobe;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lm_state_e;

endpackage

// File: rtl/cbus_line_master_buf.sv
// Line buffer: LINE_WORDS x 64 registers with parallel load, indexed write/read and a flat line view.
module cbus_line_buf
    import cbus_line_master_pkg::*;
#(
    parameter int unsigned LINE_WORDS = CBUS_LINE_WORDS,
    parameter int unsigned IDX_W      = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [LINE_WORDS*64-1:0] load_line,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [63:0]              wr_data,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [63:0]              rd_data,
    output logic [LINE_WORDS*64-1:0] line
);

    logic [63:0] words [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(LINE_WORDS); i++) words[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < int'(LINE_WORDS); i++) words[i] <= load_line[i*64 +: 64];
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    assign rd_data = words[rd_idx];

    always_comb begin
        line = '0;
        for (int i = 0; i < int'(LINE_WORDS); i++) line[i*64 +: 64] = words[i];
    end

endmodule

// File: rtl/cbus_line_master.sv
// CBus line initiator: one INCR burst per cache-line refill or writeback.
// Optional beat/last cross-check and counter-based termination under CBUS_LAST_CHECK_EN.
module cbus_line_master
    import cbus_line_master_pkg::*;
#(
    parameter int unsigned LINE_WORDS  = CBUS_LINE_WORDS,
    parameter int unsigned OFFSET_BITS = $clog2(LINE_WORDS) + 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_is_write,
    input  logic [63:0]              req_addr,
    input  logic [LINE_WORDS*64-1:0] req_wline,
    output logic                     done,
    output logic [LINE_WORDS*64-1:0] rline,
    output logic                     err,
    output cbus_req_t                oreq,
    input  cbus_resp_t               oresp
);

    localparam int unsigned BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [63:0] ADDR_MASK = ~((64'd1 << OFFSET_BITS) - 64'd1);

    lm_state_e         state, state_nxt;
    logic [BEAT_W-1:0] beat;
    logic [63:0]       base;
    logic              is_write;
    logic [63:0]       buf_rdata;
    logic              accept_c, beat_done_c, term_c;

    assign accept_c    = (state == ST_IDLE) && req_valid;
    assign beat_done_c = (state == ST_BUSY) && oresp.ready;

`ifdef CBUS_LAST_CHECK_EN
    assign term_c = beat_done_c && (beat == LAST_BEAT);
`else
    assign term_c = beat_done_c && oresp.last;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept_c) state_nxt = ST_BUSY;
            ST_BUSY: if (term_c)   state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        oreq      = '0;
        req_ready = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_BUSY: begin
                oreq.valid    = 1'b1;
                oreq.is_write = is_write;
                oreq.addr     = base;
                oreq.burst    = AXI_BURST_INCR;
                oreq.size     = MSIZE8;
                oreq.len      = 8'(LINE_WORDS - 1);
                oreq.data     = buf_rdata;
                oreq.strobe   = is_write ? 8'hFF : 8'h00;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Transaction context latched on acceptance; beat counter advances per handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat     <= '0;
            base     <= '0;
            is_write <= 1'b0;
        end else if (accept_c) begin
            beat     <= '0;
            base     <= req_addr & ADDR_MASK;
            is_write <= req_is_write;
        end else if (beat_done_c) begin
            beat <= beat + BEAT_W'(1);
        end
    end

`ifdef CBUS_LAST_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (beat_done_c && (oresp.last != (beat == LAST_BEAT))) begin
            err <= 1'b1;
            $error("cbus_line_master: last=%0b on beat %0d", oresp.last, beat);
        end
    end
`else
    assign err = 1'b0;
`endif

    cbus_line_buf #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (BEAT_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (accept_c && req_is_write),
        .load_line (req_wline),
        .wr_en     (beat_done_c && !is_write),
        .wr_idx    (beat),
        .wr_data   (oresp.data),
        .rd_idx    (beat),
        .rd_data   (buf_rdata),
        .line      (rline)
    );

endmodule

// File: tb/tb_cbus_line_master.sv
// Scoreboard bench for cbus_line_master with a behavioural CBus-to-SRAM responder.
module tb_cbus_line_master;
    import cbus_line_master_pkg::*;

    localparam int unsigned LW     = 8;
    localparam int unsigned LINE_W = LW * 64;
    localparam logic [63:0] LMASK  = ~64'(LW * 8 - 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_is_write = 1'b0;
    logic [63:0]       req_addr = '0;
    logic [LINE_W-1:0] req_wline = '0;
    logic              done;
    logic [LINE_W-1:0] rline;
    logic              err;
    cbus_req_t         oreq;
    cbus_resp_t        oresp;

    cbus_line_master #(.LINE_WORDS(LW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_write (req_is_write),
        .req_addr     (req_addr),
        .req_wline    (req_wline),
        .done         (done),
        .rline        (rline),
        .err          (err),
        .oreq         (oreq),
        .oresp        (oresp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SRAM image; untouched locations return an address-derived pattern
    logic [63:0] mem [logic [63:0]];

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 64'hC0DE_5A5A_0000_0000;
    endfunction

    int cyc = 0;
    int rbeat = 0;
    int stall_cnt = 0;
    bit stall_en = 1'b0;
    int force_last = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        oresp       = '0;
        oresp.ready = !(stall_en && (rbeat == 2 || rbeat == 5) && stall_cnt < 3);
        oresp.data  = mem_rd(oreq.addr + 64'(rbeat * 8));
        oresp.last  = (rbeat == int'(LW) - 1) || (rbeat == force_last);
    end

    always @(posedge clk) begin
        if (reset || !oreq.valid) begin
            rbeat     <= 0;
            stall_cnt <= 0;
        end else if (oresp.ready) begin
            rbeat     <= rbeat + 1;
            stall_cnt <= 0;
        end else begin
            stall_cnt <= stall_cnt + 1;
        end
    end

    typedef struct {
        bit                wr;
        logic [LINE_W-1:0] line;
        int                acc;
        int                lat;
        bit                chk_line;
        bit                err;
    } exp_t;

    exp_t              sb[$];
    logic [63:0]       cur_base = '0;
    bit                cur_wr = 1'b0;
    logic [LINE_W-1:0] cur_wline = '0;
    int                acc_cnt = 0;
    int                last_acc = 0;
    int                done_cnt = 0;
    int                last_done = 0;
    bit                done_prev = 1'b0;
    bit                stall_prev = 1'b0;
    cbus_req_t         prev_req;

    // Acceptance: build the expected outcome from the bench's own memory image
    always @(negedge clk) begin
        if (!reset && req_valid && req_ready) begin
            exp_t e;
            int   busy;
            cur_base  = req_addr & LMASK;
            cur_wr    = req_is_write;
            cur_wline = req_wline;
            e.wr       = req_is_write;
            e.acc      = cyc;
            e.err      = 1'b0;
            e.chk_line = !req_is_write;
            for (int i = 0; i < int'(LW); i++) e.line[i*64 +: 64] = mem_rd(cur_base + 64'(i * 8));
            busy = int'(LW) + (stall_en ? 6 : 0);
            if (force_last >= 0) begin
`ifdef CBUS_LAST_CHECK_EN
                e.err = 1'b1;
`else
                busy       = force_last + 1;
                e.chk_line = 1'b0;
`endif
            end
            e.lat = busy + 2;
            sb.push_back(e);
            acc_cnt++;
            last_acc = cyc;
        end
    end

    // Per-beat request checks and write capture into the SRAM image
    always @(negedge clk) begin
        if (!reset && oreq.valid) begin
            if (oresp.ready) begin
                check("addr", LINE_W'(oreq.addr), LINE_W'(cur_base));
                check("hdr", LINE_W'({oreq.is_write, oreq.burst, oreq.size, oreq.len, oreq.strobe}),
                      LINE_W'({cur_wr, AXI_BURST_INCR, MSIZE8, 8'd7, cur_wr ? 8'hFF : 8'h00}));
                if (oreq.is_write) begin
                    check("wdata", LINE_W'(oreq.data), LINE_W'(cur_wline[rbeat*64 +: 64]));
                    mem[oreq.addr + 64'(rbeat * 8)] = oreq.data;
                end
            end else if (stall_prev) begin
                check("stall_hold", LINE_W'(oreq), LINE_W'(prev_req));
            end
            stall_prev = !oresp.ready;
            prev_req   = oreq;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Completion: pop and compare against the scoreboard
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            last_done = cyc;
            check("done_pulse", LINE_W'(done_prev), LINE_W'(1'b0));
            check("ready_in_done", LINE_W'(req_ready), LINE_W'(1'b0));
            if (sb.size() == 0) begin
                check("sb_empty", LINE_W'(1'b1), LINE_W'(1'b0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("latency", LINE_W'(cyc - e.acc + 1), LINE_W'(e.lat));
                check("err", LINE_W'(err), LINE_W'(e.err));
                if (e.chk_line) check("rline", rline, e.line);
            end
        end
        done_prev = done;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target);
        int b = 0;
        while (acc_cnt < target && b < 100) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (acc_cnt < target) check("accept_timeout", LINE_W'(acc_cnt), LINE_W'(target));
    endtask

    task automatic wait_done(input int target);
        int b = 0;
        while (done_cnt < target && b < 200) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (done_cnt < target) check("done_timeout", LINE_W'(done_cnt), LINE_W'(target));
        tick(1);
    endtask

    task automatic issue(input bit wr, input logic [63:0] a, input logic [LINE_W-1:0] wl);
        int n;
        n            = acc_cnt + 1;
        req_valid    = 1'b1;
        req_is_write = wr;
        req_addr     = a;
        req_wline    = wl;
        wait_acc(n);
        req_valid = 1'b0;
    endtask

    function automatic logic [LINE_W-1:0] mk_line(input logic [63:0] seed);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < int'(LW); i++) l[i*64 +: 64] = seed + 64'(i);
        return l;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        tick(3);
        check("rst_ready", LINE_W'(req_ready), LINE_W'(1'b1));
        check("rst_oreq", LINE_W'(oreq), LINE_W'(0));
        check("rst_done_err", LINE_W'({done, err}), LINE_W'(2'b00));
        check("rst_rline", rline, LINE_W'(0));
        reset = 1'b0;
        tick(1);

        issue(1'b0, 64'h8000_0038, '0);
        wait_done(1);

        issue(1'b1, 64'h8000_0040, mk_line(64'h1111_0000));
        wait_done(2);
        for (int i = 0; i < int'(LW); i++)
            check("wb_mem", LINE_W'(mem_rd(64'h8000_0040 + 64'(i * 8))), LINE_W'(64'h1111_0000 + 64'(i)));

        issue(1'b0, 64'h8000_0040, '0);
        wait_done(3);

        stall_en = 1'b1;
        issue(1'b0, 64'h8000_0080, '0);
        wait_done(4);
        stall_en = 1'b0;

        // Held req_valid across DONE: second request must wait for IDLE
        req_valid    = 1'b1;
        req_is_write = 1'b0;
        req_addr     = 64'h8000_00C8;
        wait_acc(5);
        req_is_write = 1'b1;
        req_addr     = 64'h8000_0100;
        req_wline    = mk_line(64'h2222_0000);
        wait_acc(6);
        req_valid = 1'b0;
        check("b2b_gap", LINE_W'(last_acc - last_done), LINE_W'(1));
        wait_done(6);

        issue(1'b0, 64'h8000_0140, '0);
        b = 0;
        while (rbeat != 3 && b < 50) begin
            tick(1);
            b++;
        end
        check("reach_beat3", LINE_W'(rbeat), LINE_W'(3));
        reset = 1'b1;
        tick(1);
        check("rst_mid_valid", LINE_W'(oreq.valid), LINE_W'(1'b0));
        check("rst_mid_done", LINE_W'(done), LINE_W'(1'b0));
        check("rst_mid_rline", rline, LINE_W'(0));
        check("rst_mid_pending", LINE_W'(sb.size()), LINE_W'(1));
        sb.delete();
        reset = 1'b0;
        tick(2);
        check("rst_mid_ready", LINE_W'(req_ready), LINE_W'(1'b1));
        check("rst_mid_ndone", LINE_W'(done_cnt), LINE_W'(6));
        issue(1'b0, 64'h8000_0140, '0);
        wait_done(7);

        force_last = 5;
        issue(1'b0, 64'h8000_0180, '0);
        wait_done(8);
        force_last = -1;
        tick(3);
`ifdef CBUS_LAST_CHECK_EN
        check("err_sticky", LINE_W'(err), LINE_W'(1'b1));
`else
        check("err_tied", LINE_W'(err), LINE_W'(1'b0));
`endif
        check("sb_drained", LINE_W'(sb.size()), LINE_W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
